// File: rtl/rgb_pkg.sv
// Shared constants and helpers for the RGB PWM driver.
// Contents: word and channel widths, the last phase value, the slice offset
// of each colour channel within the 24-bit word, and a channel-extract helper.
package rgb_pkg;

  localparam int RGB_W     = 24;
  localparam int CH_W      = 8;
  localparam int PHASE_MAX = 254;
  localparam int PRE_W     = 16;

  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  typedef logic [CH_W-1:0] duty_t;

  // Pull one 8-bit channel out of a packed colour word.
  function automatic duty_t chan(input logic [RGB_W-1:0] word, input int lsb);
    return word[lsb +: CH_W];
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Bus bundle between the colour source and the RGB PWM driver.
// master: drives rgb_in/load/enable and observes the LED side.
// slave : the driver; receives the colour word and produces the PWM outputs,
//         the period_start pulse and the pending flag.
interface rgb_pwm_driver_if;
  import rgb_pkg::*;

  logic [RGB_W-1:0] rgb_in;
  logic             load;
  logic             enable;
  logic             pwm_r;
  logic             pwm_g;
  logic             pwm_b;
  logic             period_start;
  logic             pending;

  modport master (
    output rgb_in, load, enable,
    input  pwm_r, pwm_g, pwm_b, period_start, pending
  );

  modport slave (
    input  rgb_in, load, enable,
    output pwm_r, pwm_g, pwm_b, period_start, pending
  );

endinterface

// File: rtl/pwm_channel_cmp.sv
// One PWM colour channel: holds the active duty value and the registered
// compare output.
// Ports: clk/rst (async active-high), enable (run PWM), commit (load duty_next
// into the active duty), duty_next (pending channel value), phase (shared
// phase counter), pwm (registered LED output).
module pwm_channel_cmp
  import rgb_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  enable,
  input  logic  commit,
  input  duty_t duty_next,
  input  duty_t phase,
  output logic  pwm
);

  duty_t duty_r;
  logic  out_r;

  // Active duty register, replaced only when the top signals a commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_r <= 8'd0;
    end else if (commit) begin
      duty_r <= duty_next;
    end else begin
      duty_r <= duty_r;
    end
  end

  // Registered compare; phase never exceeds 254, so duty 255 stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r <= 1'b0;
    end else begin
      out_r <= enable & (phase < duty_r);
    end
  end

  assign pwm = out_r;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM LED driver with a double-buffered colour word.
// A loaded word waits in a pending buffer and becomes active only at a period
// wrap (or on any cycle while disabled), so a period is never altered midway.
// Ports: clk, rst (async active-high), bus (slave side of rgb_pwm_driver_if:
// rgb_in, load, enable in; pwm_r/g/b, period_start, pending out).
// Parameter PRESCALE: clk cycles per phase step, 1..65535.
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input logic               clk,
  input logic               rst,
  rgb_pwm_driver_if.slave   bus
);

  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(PRESCALE - 32'd1);
  localparam duty_t            PHASE_LAST = CH_W'(PHASE_MAX);

  logic [PRE_W-1:0] prescaler_r;
  duty_t            phase_r;
  logic [RGB_W-1:0] pend_r;
  logic             pending_r;
  logic             period_start_r;

  logic tick_s;
  logic wrap_s;
  logic commit_s;

  // Step/wrap decode; while disabled every cycle is a commit opportunity.
  always_comb begin
    tick_s   = (prescaler_r == PRE_LAST);
    wrap_s   = bus.enable & tick_s & (phase_r == PHASE_LAST);
    commit_s = pending_r & (wrap_s | ~bus.enable);
  end

  // Prescaler and phase counter; both parked at zero while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_r <= 16'd0;
      phase_r     <= 8'd0;
    end else if (!bus.enable) begin
      prescaler_r <= 16'd0;
      phase_r     <= 8'd0;
    end else if (tick_s) begin
      prescaler_r <= 16'd0;
      phase_r     <= wrap_s ? 8'd0 : (phase_r + 8'd1);
    end else begin
      prescaler_r <= prescaler_r + 16'd1;
      phase_r     <= phase_r;
    end
  end

  // Pending buffer; a load in a commit cycle re-arms pending for the next one,
  // while the commit itself consumes the previous buffer contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r    <= 24'd0;
      pending_r <= 1'b0;
    end else begin
      if (bus.load) begin
        pend_r <= bus.rgb_in;
      end else begin
        pend_r <= pend_r;
      end
      pending_r <= bus.load | (pending_r & ~commit_s);
    end
  end

  // Period start marks the first clk of phase 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_start_r <= 1'b0;
    end else begin
      period_start_r <= bus.enable & (phase_r == 8'd0) & (prescaler_r == 16'd0);
    end
  end

  pwm_channel_cmp u_red (
    .clk       (clk),
    .rst       (rst),
    .enable    (bus.enable),
    .commit    (commit_s),
    .duty_next (chan(pend_r, R_LSB)),
    .phase     (phase_r),
    .pwm       (bus.pwm_r)
  );

  pwm_channel_cmp u_green (
    .clk       (clk),
    .rst       (rst),
    .enable    (bus.enable),
    .commit    (commit_s),
    .duty_next (chan(pend_r, G_LSB)),
    .phase     (phase_r),
    .pwm       (bus.pwm_g)
  );

  pwm_channel_cmp u_blue (
    .clk       (clk),
    .rst       (rst),
    .enable    (bus.enable),
    .commit    (commit_s),
    .duty_next (chan(pend_r, B_LSB)),
    .phase     (phase_r),
    .pwm       (bus.pwm_b)
  );

  assign bus.period_start = period_start_r;
  assign bus.pending      = pending_r;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: two instances (PRESCALE 1 and 4) share stimulus;
// a behavioural model predicts every output each cycle, and directed
// scenarios pin the model with hand-computed counts.
module tb_rgb_pwm_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] rgb_in;
  logic        load;
  logic        enable;

  always #5 clk = ~clk;

  rgb_pwm_driver_if bus0 ();
  rgb_pwm_driver_if bus1 ();

  assign bus0.rgb_in = rgb_in;
  assign bus0.load   = load;
  assign bus0.enable = enable;
  assign bus1.rgb_in = rgb_in;
  assign bus1.load   = load;
  assign bus1.enable = enable;

  rgb_pwm_driver #(.PRESCALE(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  rgb_pwm_driver #(.PRESCALE(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int tests = 0;
  int fails = 0;

  // Behavioural model state, one set per instance.
  int presc [2] = '{1, 4};
  int m_pre [2];
  int m_phase [2];
  int m_duty [2][3];
  int m_pend [2][3];
  bit m_pending [2];
  bit m_wrap;
  bit e_pwm [2][3];
  bit e_ps [2];
  bit e_pending [2];

  // Model: one period is 255 phase steps of presc clk each; the output seen
  // after a clk edge reflects the phase/duty in force before that edge.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          m_pre[d] = 0; m_phase[d] = 0; m_pending[d] = 0;
          e_ps[d] = 0; e_pending[d] = 0;
          for (int c = 0; c < 3; c++) begin
            m_duty[d][c] = 0; m_pend[d][c] = 0; e_pwm[d][c] = 0;
          end
        end else begin
          if (enable) begin
            for (int c = 0; c < 3; c++) e_pwm[d][c] = (m_phase[d] < m_duty[d][c]);
            e_ps[d] = (m_phase[d] == 0) && (m_pre[d] == 0);
            m_wrap = (m_pre[d] == presc[d] - 1) && (m_phase[d] == 254);
            m_pre[d] = m_pre[d] + 1;
            if (m_pre[d] == presc[d]) begin
              m_pre[d] = 0;
              m_phase[d] = (m_phase[d] + 1) % 255;
            end
          end else begin
            for (int c = 0; c < 3; c++) e_pwm[d][c] = 0;
            e_ps[d] = 0;
            m_pre[d] = 0;
            m_phase[d] = 0;
            m_wrap = 0;
          end
          if (m_pending[d] && (m_wrap || !enable)) begin
            for (int c = 0; c < 3; c++) m_duty[d][c] = m_pend[d][c];
            m_pending[d] = 0;
          end
          if (load) begin
            m_pend[d][0] = int'(rgb_in[23:16]);
            m_pend[d][1] = int'(rgb_in[15:8]);
            m_pend[d][2] = int'(rgb_in[7:0]);
            m_pending[d] = 1;
          end
          e_pending[d] = m_pending[d];
        end
      end
    end
  end

  function automatic logic [4:0] dut_out(input int d);
    if (d == 0) return {bus0.pwm_r, bus0.pwm_g, bus0.pwm_b, bus0.period_start, bus0.pending};
    else        return {bus1.pwm_r, bus1.pwm_g, bus1.pwm_b, bus1.period_start, bus1.pending};
  endfunction

  // Every-cycle comparison of both instances against the model.
  initial begin
    logic [4:0] act;
    logic [4:0] exp;
    forever begin
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        act = dut_out(d);
        exp = {e_pwm[d][0], e_pwm[d][1], e_pwm[d][2], e_ps[d], e_pending[d]};
        tests++;
        if (act !== exp) begin
          fails++;
          $display("FAIL model_cmp dut%0d t=%0t {r,g,b,ps,pend}: got %b expected %b",
                   d, $time, act, exp);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [23:0] w);
    load = 1'b1; rgb_in = w;
    step(1);
    load = 1'b0;
  endtask

  // Advance to the next negedge where period_start is high on instance d.
  task automatic wait_ps(input int d, output int hi_r);
    logic [4:0] o;
    hi_r = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      o = dut_out(d);
      if (o[1]) return;
      if (o[4]) hi_r++;
    end
    check("wait_period_start_timeout", 0, 1);
  endtask

  task automatic wait_phase(input int d, input int ph);
    for (int i = 0; i < 3000; i++) begin
      if (m_phase[d] == ph) return;
      @(negedge clk);
    end
    check("wait_phase_timeout", 0, 1);
  endtask

  // Count high cycles over n samples starting with the current one.
  task automatic measure(input int d, input int n, output int r, output int g,
                         output int b, output int ps);
    logic [4:0] o;
    r = 0; g = 0; b = 0; ps = 0;
    for (int i = 0; i < n; i++) begin
      if (i != 0) @(negedge clk);
      o = dut_out(d);
      r += int'(o[4]); g += int'(o[3]); b += int'(o[2]); ps += int'(o[1]);
    end
  endtask

  initial begin
    int r, g, b, ps, hi;
    rst = 1'b1; enable = 1'b0; load = 1'b0; rgb_in = 24'd0;
    step(3);
    check("reset_outputs", int'(dut_out(0)), 0);
    check("reset_outputs_p4", int'(dut_out(1)), 0);
    rst = 1'b0;
    step(2);

    // Load at phase 10: current period keeps duty 0.
    enable = 1'b1;
    wait_phase(0, 10);
    pulse_load(24'hFF8000);
    wait_ps(0, hi);
    check("load_mid_old_period_r", hi, 0);
    measure(0, 255, r, g, b, ps);
    check("ff8000_r_high", r, 255);
    check("ff8000_g_high", g, 128);
    check("ff8000_b_high", b, 0);
    check("ff8000_ps_count", ps, 1);

    // Two loads in one period: latest wins.
    wait_ps(0, hi);
    pulse_load(24'h000040);
    step(5);
    pulse_load(24'h0000C0);
    wait_ps(0, hi);
    check("two_loads_pending_cleared", int'(bus0.pending), 0);
    measure(0, 255, r, g, b, ps);
    check("c0_b_high", b, 192);
    check("c0_r_high", r, 0);

    // Load in the exact wrap cycle while 101010 is pending.
    wait_ps(0, hi);
    pulse_load(24'h101010);
    wait_phase(0, 254);
    pulse_load(24'h202020);
    wait_ps(0, hi);
    check("wrap_load_pending_kept", int'(bus0.pending), 1);
    measure(0, 255, r, g, b, ps);
    check("wrap_load_duty16_r", r, 16);
    check("wrap_load_duty16_b", b, 16);
    wait_ps(0, hi);
    check("wrap_load_pending_done", int'(bus0.pending), 0);
    measure(0, 255, r, g, b, ps);
    check("wrap_load_duty32_g", g, 32);

    // Enable drop, load while disabled, re-enable.
    wait_ps(0, hi);
    step(5);
    check("pre_drop_r_high", int'(bus0.pwm_r), 1);
    enable = 1'b0;
    step(1);
    check("drop_outputs_low", int'(dut_out(0) >> 1), 0);
    load = 1'b1; rgb_in = 24'h00FF00;
    step(1);
    load = 1'b0;
    check("disabled_load_pending", int'(bus0.pending), 1);
    step(1);
    check("disabled_commit_pending", int'(bus0.pending), 0);
    enable = 1'b1;
    step(1);
    check("reenable_ps", int'(bus0.period_start), 1);
    measure(0, 255, r, g, b, ps);
    check("reenable_g_high", g, 255);
    check("reenable_r_high", r, 0);

    // PRESCALE=4 instance: 1020 clk period, duty 1 -> 4 clk high.
    pulse_load(24'h010000);
    wait_ps(1, hi);
    wait_ps(1, hi);
    measure(1, 1020, r, g, b, ps);
    check("p4_r_high", r, 4);
    check("p4_ps_count", ps, 1);
    step(1);
    check("p4_ps_spacing", int'(bus1.period_start), 1);

    // Reset mid-period with pwm_r high at phase 100.
    pulse_load(24'hFF0000);
    wait_ps(0, hi);
    wait_ps(0, hi);
    wait_phase(0, 101);
    check("pre_reset_r_high", int'(bus0.pwm_r), 1);
    rst = 1'b1;
    #1;
    check("reset_async_outputs", int'(dut_out(0)), 0);
    step(2);
    rst = 1'b0;
    wait_ps(0, hi);
    measure(0, 255, r, g, b, ps);
    check("post_reset_r_high", r, 0);
    check("post_reset_ps_count", ps, 1);

    // Randomised traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 6000; i++) begin
      load = ($urandom_range(15) == 0);
      rgb_in = 24'($urandom);
      if ($urandom_range(299) == 0) enable = ~enable;
      rst = ($urandom_range(1499) == 0);
      step(1);
    end
    rst = 1'b0;
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
Downstream consumer of the RGB colour converter's 24-bit rgb word. Drives three PWM LED outputs (R, G, B) whose duty cycles equal the 8-bit channel values. New colour words are double-buffered and committed only at a PWM period boundary, so the LEDs never glitch mid-period. The integrator connects rgb_in to the converter's rgb output and drives load from the converter enable delayed one clk, which matches the memory's 1-cycle read latency.

Parameters:
PRESCALE, 1, clk cycles per PWM phase step; legal range 1..65535.
PHASE_MAX, 254, last phase value; period = (PHASE_MAX+1) phase steps; fixed at 254 so duty 255 means always on.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
rgb_in  input  24  colour word: [23:16]=R, [15:8]=G, [7:0]=B.
load  input  1  capture rgb_in into the pending buffer this cycle.
enable  input  1  run the PWM; low = outputs forced low, counters held.
pwm_r  output  1  red PWM.
pwm_g  output  1  green PWM.
pwm_b  output  1  blue PWM.
period_start  output  1  one-cycle pulse, first output cycle of each period.
pending  output  1  a loaded word is waiting to be committed.

Behaviour:
- Reset (async): prescaler=0, phase=0, pend_reg=0, active duty regs=0, pending=0, pwm_r/g/b=0, period_start=0. Reset mid-period aborts immediately; no commit.
- Prescaler: counts 0..PRESCALE-1 while enable=1; tick = (prescaler==PRESCALE-1). PRESCALE=1 -> tick every cycle.
- Phase counter: 8 bits; advances on tick; at PHASE_MAX with tick wraps to 0 (wrap event).
- Load: load=1 -> pend_reg<=rgb_in, pending<=1. Repeated loads before commit: latest wins.
- Commit at wrap event: if pending=1, active<=pend_reg and pending<=0. If pending=0, active is unchanged.
- Load and wrap in the same cycle: commit uses the old pend_reg (if pending). rgb_in is captured into pend_reg and pending is 1 afterwards, so the new value is applied at the next wrap.
- enable=0: prescaler and phase held at 0; pwm_* and period_start are 0 one cycle later. If pending=1, commit happens on every disabled cycle. Load still works and is committed on the next disabled cycle, so the first period after enable uses the latest word.
- Outputs are registered. pwm_x(t+1) = enable(t) & (phase(t) < duty_x(t)). Duty 0 means always low. Duty 255 means always high, because phase never exceeds 254.
- period_start(t+1) = enable(t) & (phase(t)==0) & (first clk of that phase step, i.e. prescaler(t)==0).
- The enable rising edge starts a period at phase 0, with period_start asserted on the next cycle.
- High time per period = duty*PRESCALE clk. Period = 255*PRESCALE clk.

Decomposition:
- Package rgb_pkg: RGB_W=24, CH_W=8, PHASE_MAX=254; channel slice offsets R_LSB=16, G_LSB=8, B_LSB=0.
- One sub-module, pwm_channel_cmp, instantiated three times. It holds one channel's active duty register and the registered compare output. Prescaler, phase, pending and commit logic live in the top.

Test Plan:
1. Reset mid-run: rst=1 while phase=100 with pwm_r high. Required: all outputs 0 in the same cycle, and after release phase restarts from 0 with duty 0.
2. PRESCALE=1, enable=1, load 24'hFF8000 at phase 10. Required: current period keeps old duty 0. From the next period: pwm_r high 255/255 cycles, pwm_g high 128/255, pwm_b 0.
3. Two loads in one period: 24'h000040, then 24'h0000C0. Required: only C0 is committed at the wrap, giving pwm_b high 192 cycles; pending=0 after the commit.
4. Load 24'h202020 in the exact wrap cycle while pending holds 24'h101010. Required: next period duty=16 on all channels, pending stays 1, and the following period duty=32.
5. enable drop mid-period, load 24'h00FF00 while disabled, re-enable. Required: outputs 0 one cycle after the drop, and pending clears on the next disabled cycle. After re-enable: period_start pulses 1 cycle after the enable rising edge and pwm_g is high continuously.
6. PRESCALE=4, load 24'h010000. Required: period 1020 clk, pwm_r high exactly 4 clk per period, period_start spacing 1020 clk.
